// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, Funct codes,
// ALU operations, mux selects and the FSM state enumeration (TRAP under ILLEGAL_OP_TRAP_EN).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select: fixed ADD/SUB for address and branch work, Funct-decoded for R-type.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] ALUControl,
  output logic       funct_illegal
);

  logic [3:0] fn_ctrl;

  always_comb begin
    fn_ctrl       = ALU_ADD;
    funct_illegal = 1'b0;
    case (Funct)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_NOR:  fn_ctrl = ALU_NOR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      FN_SLL:  fn_ctrl = ALU_SLL;
      FN_SRL:  fn_ctrl = ALU_SRL;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (ALUOp)
      ALUOP_SUB:   ALUControl = ALU_SUB;
      ALUOP_FUNCT: ALUControl = fn_ctrl;
      default:     ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath; outputs forced to 0 while reset is low.
// Optional ILLEGAL_OP_TRAP_EN adds illegal_o and a sticky TRAP state.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_STATE_INIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       instr_retired_o
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       illegal_o
`endif
);

  localparam state_t RST_ST = (RESET_STATE_INIT != 0) ? S_INIT : S_FETCH;

  state_t     state, state_nxt;
  ctrl_t      c;
  logic [1:0] alu_op;
  logic [3:0] alu_ctrl;
  logic       funct_illegal;
  logic       illegal;
  state_t     bad_st;

`ifdef ILLEGAL_OP_TRAP_EN
  assign bad_st = S_TRAP;
`else
  assign bad_st = S_FETCH;
  logic unused_funct_illegal;
  assign unused_funct_illegal = funct_illegal;
`endif

  alu_decoder u_alu_dec (
    .ALUOp        (alu_op),
    .Funct        (Funct),
    .ALUControl   (alu_ctrl),
    .funct_illegal(funct_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RST_ST;
    else        state <= state_nxt;
  end

  always_comb begin
    c         = '0;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    state_nxt = S_FETCH;
    case (state)
      S_INIT: state_nxt = S_FETCH;
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.pc_src    = PCSRC_ALU;
        state_nxt   = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        case (OP)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = (funct_illegal && bad_st != S_FETCH) ? bad_st : S_RTEXEC;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = bad_st;
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nxt   = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.iord    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_RTEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        alu_op      = ALUOP_FUNCT;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nxt   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ALUOUT;
        c.retire    = 1'b1;
        alu_op      = ALUOP_SUB;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
        c.retire   = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        illegal   = 1'b1;
        state_nxt = S_TRAP;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Gating with reset drops every strobe asynchronously, even mid-instruction.
  assign PCEn            = reset & (c.pc_write | (c.branch & Zero));
  assign IorD            = reset & c.iord;
  assign MemWrite        = reset & c.mem_write;
  assign IRWrite         = reset & c.ir_write;
  assign RegDst          = reset & c.reg_dst;
  assign MemtoReg        = reset & c.mem_to_reg;
  assign RegWrite        = reset & c.reg_write;
  assign ALUSrcA         = reset & c.alu_src_a;
  assign ALUSrcB         = {2{reset}} & c.alu_src_b;
  assign ALUControl      = {4{reset}} & alu_ctrl;
  assign PCSrc           = {2{reset}} & c.pc_src;
  assign instr_retired_o = reset & c.retire;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_o       = reset & illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected output tables derived from the
// instruction semantics, directed cases plus a randomized instruction stream.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl;
  logic       instr_retired_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       pcen, iord, memw, irw, regdst, m2r, regw, srca;
    logic [1:0] srcb;
    logic [3:0] aluc;
    logic [1:0] pcsrc;
    logic       ret;
  } outs_t;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .instr_retired_o(instr_retired_o)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic outs_t observe();
    return {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, instr_retired_o};
  endfunction

  function automatic logic [3:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0100;
      6'b100010: return 4'b0101;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b0010;
      6'b101010: return 4'b1000;
      6'b000000: return 4'b0110;
      6'b000010: return 4'b0111;
      default:   return 4'b0100;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic int n_cycles(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = FETCH) of an instruction; care=0 means ALUControl is free.
  function automatic void expect_out(input logic [5:0] op, input logic [5:0] fn, input int k,
                                     input logic z, output outs_t e, output bit care);
    e = '0; care = 1'b0;
    if (k == 0) begin
      e.irw = 1; e.pcen = 1; e.srcb = 2'b01; e.aluc = 4'b0100; care = 1;
    end else if (k == 1) begin
      e.srcb = 2'b11; e.aluc = 4'b0100; care = 1;
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (k == 2) begin e.srca = 1; e.srcb = 2'b10; e.aluc = 4'b0100; care = 1; end
          else if (op == 6'b101011) begin e.iord = 1; e.memw = 1; e.ret = 1; end
          else if (k == 3) e.iord = 1;
          else begin e.m2r = 1; e.regw = 1; e.ret = 1; end
        end
        6'b000000: begin
          if (k == 2) begin e.srca = 1; e.aluc = alu_ref(fn); care = 1; end
          else begin e.regdst = 1; e.regw = 1; e.ret = 1; end
        end
        6'b001000: begin
          if (k == 2) begin e.srca = 1; e.srcb = 2'b10; e.aluc = 4'b0100; care = 1; end
          else begin e.regw = 1; e.ret = 1; end
        end
        6'b000100: begin
          e.srca = 1; e.aluc = 4'b0101; care = 1; e.pcen = z; e.pcsrc = 2'b01; e.ret = 1;
        end
        6'b000010: begin e.pcen = 1; e.pcsrc = 2'b10; e.ret = 1; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] masked(input outs_t v, input bit care);
    outs_t m;
    m = '1;
    if (!care) m.aluc = '0;
    return 32'(v & m);
  endfunction

  // zmode: 0/1 force Zero, other = random. abort_k: cycle at which reset is pulsed (-1 none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int abort_k);
    outs_t e, o;
    bit care;
    for (int k = 0; k < n_cycles(op); k++) begin
      @(negedge clk);
      if (k == 0) begin OP = op; Funct = fn; end
      Zero = (zmode == 0 || zmode == 1) ? zmode[0] : 1'($urandom);
      #1;
      expect_out(op, fn, k, Zero, e, care);
      o = observe();
      chk($sformatf("op%b_fn%b_k%0d", op, fn, k), masked(o, care), masked(e, care));
      if (k == abort_k) begin
        #2 reset = 1'b0;
        #1 chk("rst_memwrite_async", 32'(MemWrite), 32'd0);
        chk("rst_all_zero", 32'(observe()), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 chk("init_after_rst", masked(observe(), 1'b0), 32'd0);
        return;
      end
    end
  endtask

  logic [5:0] legal_fn [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100111, 6'b101010, 6'b000000, 6'b000010};
  logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    logic [5:0] op, fn;
    reset = 1'b0; OP = '0; Funct = '0; Zero = 1'b0;
    #12 chk("reset_outputs", 32'(observe()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("init_cycle", masked(observe(), 1'b0), 32'd0);

    run_instr(6'b100011, 6'b000000, -1, -1);   // lw
    run_instr(6'b000000, 6'b100010, -1, -1);   // sub
    run_instr(6'b000000, 6'b101010, -1, -1);   // slt
    run_instr(6'b000100, 6'b000000, 1, -1);    // beq taken
    run_instr(6'b000100, 6'b000000, 0, -1);    // beq not taken
    run_instr(6'b000010, 6'b000000, -1, -1);   // j
    run_instr(6'b001000, 6'b000000, -1, -1);   // addi
    run_instr(6'b101011, 6'b000000, -1, 3);    // sw, reset in MEMWR
`ifndef ILLEGAL_OP_TRAP_EN
    run_instr(6'b111111, 6'b000000, -1, -1);   // unknown op falls back to FETCH
`endif

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 5)];
      fn = legal_fn[$urandom_range(0, 7)];
`ifndef ILLEGAL_OP_TRAP_EN
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (legal_op(op));
      end
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
`endif
      run_instr(op, fn, -1, -1);
    end

`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(6'b111111, 6'b000000, -1, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("trap_illegal", 32'(illegal_o), 32'd1);
      chk("trap_outputs", masked(observe(), 1'b0), 32'd0);
    end
`endif
    // a final fetch after the random stream confirms the FSM is back in sync
    @(negedge clk); #1;
`ifndef ILLEGAL_OP_TRAP_EN
    chk("final_fetch", masked(observe(), 1'b0),
        masked(outs_t'({1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 2'b01, 4'b0, 2'b00, 1'b0}), 1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
